mandelbrot_pixel_writer: RTL and testbench

- Upstream neighbour of the VGA output stage: takes per-pixel results from the Mandelbrot compute engine in raster order, converts iteration counts to 12-bit RGB and writes them into the banded frame buffer the VGA stage reads.
- Frame buffer is split into 16 bands of BAND_ROWS half-resolution rows × FB_WIDTH pixels.
- The band index goes out on o_band, in the same encoding the VGA stage uses for its line mux.
- Owns the raster coordinate counters and tells the compute engine which pixel is due next.

---
 rtl/mandelbrot_pkg.sv | 37 +++
 rtl/mandelbrot_palette.sv | 32 +++
 rtl/mandelbrot_pixel_writer.sv | 150 +++++++++++++++
 tb/tb_mandelbrot_pixel_writer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared geometry, colour type and FSM state encoding for the Mandelbrot pixel writer.
// Build option: define PALETTE_ROM_EN to colour escaped pixels from a 16-entry palette ROM.
package mandelbrot_pkg;

  localparam int unsigned FB_WIDTH   = 320;
  localparam int unsigned FB_HEIGHT  = 240;
  localparam int unsigned BAND_ROWS  = 15;
  localparam int unsigned NUM_BANDS  = 16;

  localparam int unsigned X_WIDTH    = 9;
  localparam int unsigned Y_WIDTH    = 8;
  localparam int unsigned ROW_WIDTH  = 4;
  localparam int unsigned BAND_WIDTH = 4;

  // RGB444 pixel colour, packed as {R, G, B}
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Direct bit mapping of an iteration count onto RGB444
  function automatic rgb444_t direct_colour(input logic [7:0] iter);
    rgb444_t c;
    c.r = iter[3:0];
    c.g = iter[5:2];
    c.b = iter[7:4];
    return c;
  endfunction

endpackage

// File: rtl/mandelbrot_palette.sv
// Combinational 16-entry palette: blue at index 0 ramping up to white at index 15.
module mandelbrot_palette
  import mandelbrot_pkg::*;
(
  input  logic [3:0] index,
  output rgb444_t    colour_c
);

  // Palette ROM lookup
  always_comb begin
    colour_c = '0;
    case (index)
      4'd0:    colour_c = 12'h00F;
      4'd1:    colour_c = 12'h11F;
      4'd2:    colour_c = 12'h22F;
      4'd3:    colour_c = 12'h33F;
      4'd4:    colour_c = 12'h44F;
      4'd5:    colour_c = 12'h55F;
      4'd6:    colour_c = 12'h66F;
      4'd7:    colour_c = 12'h77F;
      4'd8:    colour_c = 12'h88F;
      4'd9:    colour_c = 12'h99F;
      4'd10:   colour_c = 12'hAAF;
      4'd11:   colour_c = 12'hBBF;
      4'd12:   colour_c = 12'hCCF;
      4'd13:   colour_c = 12'hDDF;
      4'd14:   colour_c = 12'hEEF;
      default: colour_c = 12'hFFF;
    endcase
  end

endmodule

// File: rtl/mandelbrot_pixel_writer.sv
// Raster-order pixel writer: accepts Mandelbrot iteration results, colours them and
// writes them into the 16-band frame buffer with one cycle of latency.
// Build option: PALETTE_ROM_EN selects the palette ROM instead of direct bit mapping.
module mandelbrot_pixel_writer
  import mandelbrot_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ITER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ITER_WIDTH-1:0] i_iter,
  input  logic                  i_escaped,
  output logic [X_WIDTH-1:0]    o_x,
  output logic [Y_WIDTH-1:0]    o_y,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr_wr,
  output logic [DATA_WIDTH-1:0] o_data_wr,
  output logic [BAND_WIDTH-1:0] o_band,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam logic [X_WIDTH-1:0]    X_LAST    = X_WIDTH'(FB_WIDTH - 1);
  localparam logic [Y_WIDTH-1:0]    Y_LAST    = Y_WIDTH'(FB_HEIGHT - 1);
  localparam logic [ROW_WIDTH-1:0]  ROW_LAST  = ROW_WIDTH'(BAND_ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_PITCH = ADDR_WIDTH'(FB_WIDTH);

  state_t                 state;
  state_t                 state_n;

  logic [X_WIDTH-1:0]     x;
  logic [Y_WIDTH-1:0]     y;
  logic [ROW_WIDTH-1:0]   row_in_band;
  logic [BAND_WIDTH-1:0]  band;
  logic [ADDR_WIDTH-1:0]  row_base;

  logic                   accept_c;
  logic                   last_pixel_c;
  rgb444_t                colour_c;
  rgb444_t                pixel_colour_c;

  assign accept_c     = i_valid && o_ready;
  assign last_pixel_c = (x == X_LAST) && (y == Y_LAST);

`ifdef PALETTE_ROM_EN
  logic [ITER_WIDTH-1:0] unused_iter;
  assign unused_iter = i_iter;

  mandelbrot_palette u_palette (
    .index    (i_iter[3:0]),
    .colour_c (colour_c)
  );
`else
  assign colour_c = direct_colour(i_iter[7:0]);
`endif

  // Pixels inside the set are always black
  assign pixel_colour_c = i_escaped ? colour_c : rgb444_t'(12'h000);

  // FSM state register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; FLUSH is the single cycle carrying the final write
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (i_start) state_n = RUN;
      RUN:     if (accept_c && last_pixel_c) state_n = FLUSH;
      FLUSH:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake and status flags, registered from the next state
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ready <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_ready <= (state_n == RUN);
      o_busy  <= (state_n == RUN);
    end
  end

  // Raster counters; row_base tracks row_in_band*FB_WIDTH without a multiplier
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x           <= '0;
      y           <= '0;
      row_in_band <= '0;
      band        <= '0;
      row_base    <= '0;
    end else if ((state == IDLE) && i_start) begin
      x           <= '0;
      y           <= '0;
      row_in_band <= '0;
      band        <= '0;
      row_base    <= '0;
    end else if (accept_c) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + Y_WIDTH'(1);
        if (row_in_band == ROW_LAST) begin
          row_in_band <= '0;
          row_base    <= '0;
          band        <= band + BAND_WIDTH'(1);
        end else begin
          row_in_band <= row_in_band + ROW_WIDTH'(1);
          row_base    <= row_base + ROW_PITCH;
        end
      end else begin
        x <= x + X_WIDTH'(1);
      end
    end
  end

  // Frame-buffer write register: one-cycle latency from accept
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_we         <= 1'b0;
      o_addr_wr    <= '0;
      o_data_wr    <= '0;
      o_band       <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_we         <= accept_c;
      o_frame_done <= accept_c && last_pixel_c;
      if (accept_c) begin
        o_addr_wr <= row_base + ADDR_WIDTH'(x);
        o_data_wr <= DATA_WIDTH'(pixel_colour_c);
        o_band    <= band;
      end
    end
  end

  assign o_x = x;
  assign o_y = y;

endmodule

// File: tb/tb_mandelbrot_pixel_writer.sv
// Directed bench for mandelbrot_pixel_writer: vector table, band boundary,
// full frame with gaps, and reset mid-frame.
module tb_mandelbrot_pixel_writer;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_iter;
  logic        i_escaped;
  logic [8:0]  o_x;
  logic [7:0]  o_y;
  logic        o_we;
  logic [12:0] o_addr_wr;
  logic [11:0] o_data_wr;
  logic [3:0]  o_band;
  logic        o_busy;
  logic        o_frame_done;

  mandelbrot_pixel_writer dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_iter       (i_iter),
    .i_escaped    (i_escaped),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_we         (o_we),
    .o_addr_wr    (o_addr_wr),
    .o_data_wr    (o_data_wr),
    .o_band       (o_band),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: 0 idle, 1 run, 2 flush
  int m_state, m_x, m_y;
  bit m_pend, m_done;
  int m_addr, m_band, m_data;
  int n_we, n_done, done_addr, done_band;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int model_col(input int iter, input bit esc);
    logic [7:0] it;
    it = iter[7:0];
    if (!esc) return 0;
`ifdef PALETTE_ROM_EN
    return 32'({it[3:0], it[3:0], 4'hF});
`else
    return 32'({it[3:0], it[5:2], it[7:4]});
`endif
  endfunction

  // One clock: drive inputs, step the model, compare all outputs
  task automatic cyc(input bit v, input int it, input bit e, input bit st);
    i_valid   = v;
    i_iter    = 8'(it);
    i_escaped = e;
    i_start   = st;
    @(posedge clk);
    #1;
    m_pend = 1'b0;
    m_done = 1'b0;
    case (m_state)
      0: if (st) begin m_state = 1; m_x = 0; m_y = 0; end
      1: if (v) begin
           m_pend = 1'b1;
           m_addr = (m_y % 15) * 320 + m_x;
           m_band = m_y / 15;
           m_data = model_col(it, e);
           if (m_x == 319 && m_y == 239) begin m_done = 1'b1; m_state = 2; end
           m_x++;
           if (m_x == 320) begin m_x = 0; m_y++; end
         end
      default: m_state = 0;
    endcase
    chk("we", 32'(o_we), 32'(m_pend));
    if (m_pend) begin
      chk("addr", 32'(o_addr_wr), m_addr);
      chk("band", 32'(o_band), m_band);
      chk("data", 32'(o_data_wr), m_data);
    end
    chk("frame_done", 32'(o_frame_done), 32'(m_done));
    chk("ready", 32'(o_ready), 32'(m_state == 1));
    chk("busy", 32'(o_busy), 32'(m_state == 1));
    if (m_state == 1) begin
      chk("x", 32'(o_x), m_x);
      chk("y", 32'(o_y), m_y);
    end
    if (o_we) n_we++;
    if (o_frame_done) begin
      n_done++;
      done_addr = 32'(o_addr_wr);
      done_band = 32'(o_band);
    end
  endtask

  typedef struct {
    bit v; int it; bit e; bit st;
    bit ready; bit we; int addr; int band; int data; int x; int y;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // valid iter esc start | ready we addr band data x y
    tbl[0] = '{0, 0,     0, 1, 1, 0, 0, 0, 0, 0, 0};
`ifdef PALETTE_ROM_EN
    tbl[1] = '{1, 'h37,  1, 0, 1, 1, 0, 0, 'h77F, 1, 0};
    tbl[4] = '{1, 'hA5,  1, 1, 1, 1, 2, 0, 'h55F, 3, 0};
    tbl[6] = '{1, 'h00,  1, 0, 1, 1, 3, 0, 'h00F, 4, 0};
`else
    tbl[1] = '{1, 'h37,  1, 0, 1, 1, 0, 0, 'h7D3, 1, 0};
    tbl[4] = '{1, 'hA5,  1, 1, 1, 1, 2, 0, 'h59A, 3, 0};
    tbl[6] = '{1, 'h00,  1, 0, 1, 1, 3, 0, 'h000, 4, 0};
`endif
    tbl[2] = '{0, 0,     0, 0, 1, 0, 0, 0, 0, 1, 0};
    tbl[3] = '{1, 'hFF,  0, 0, 1, 1, 1, 0, 'h000, 2, 0};
    tbl[5] = '{0, 0,     0, 1, 1, 0, 0, 0, 0, 3, 0};

    m_state = 0; m_x = 0; m_y = 0;
    n_we = 0; n_done = 0; done_addr = -1; done_band = -1;
    i_rst_n = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_iter = '0; i_escaped = 1'b0;

    // Reset state
    #2;
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_we", 32'(o_we), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_frame_done), 0);
    chk("rst_addr", 32'(o_addr_wr), 0);
    chk("rst_data", 32'(o_data_wr), 0);
    chk("rst_band", 32'(o_band), 0);
    chk("rst_x", 32'(o_x), 0);
    chk("rst_y", 32'(o_y), 0);
    @(posedge clk); @(posedge clk); #1;
    i_rst_n = 1'b1;
    cyc(0, 0, 0, 0);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].v, tbl[i].it, tbl[i].e, tbl[i].st);
      chk($sformatf("tv%0d_ready", i), 32'(o_ready), 32'(tbl[i].ready));
      chk($sformatf("tv%0d_we", i), 32'(o_we), 32'(tbl[i].we));
      chk($sformatf("tv%0d_x", i), 32'(o_x), tbl[i].x);
      chk($sformatf("tv%0d_y", i), 32'(o_y), tbl[i].y);
      if (tbl[i].we) begin
        chk($sformatf("tv%0d_addr", i), 32'(o_addr_wr), tbl[i].addr);
        chk($sformatf("tv%0d_band", i), 32'(o_band), tbl[i].band);
        chk($sformatf("tv%0d_data", i), 32'(o_data_wr), tbl[i].data);
      end
    end

    // Stream up to the band 0 / band 1 boundary
    while (m_y * 320 + m_x < 4799) cyc(1, $urandom_range(255), 1'($urandom_range(1)), 0);
    cyc(1, 'h12, 1, 0);
    chk("b0_last_addr", 32'(o_addr_wr), 4799);
    chk("b0_last_band", 32'(o_band), 0);
    cyc(1, 'h34, 1, 0);
    chk("b1_first_addr", 32'(o_addr_wr), 0);
    chk("b1_first_band", 32'(o_band), 1);
    chk("b1_x", 32'(o_x), 1);
    chk("b1_y", 32'(o_y), 15);

    // Remainder of the frame with sparse valid gaps and one ignored start pulse
    for (int c = 0; c < 90000 && m_state == 1; c++) begin
      cyc(($urandom_range(31) != 0), $urandom_range(255), 1'($urandom_range(1)), (c == 20000));
    end
    chk("frame_timeout", 32'(m_state == 1), 0);
    for (int c = 0; c < 4; c++) cyc(1, 'h55, 1, 0);
    chk("write_count", n_we, 76800);
    chk("done_count", n_done, 1);
    chk("done_addr", done_addr, 4799);
    chk("done_band", done_band, 15);

    // Reset in the middle of a frame, with a write pending
    cyc(0, 0, 0, 1);
    while (m_y * 320 + m_x < 1000) cyc(1, $urandom_range(255), 1, 0);
    chk("pre_rst_we", 32'(o_we), 1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(o_we), 0);
    chk("mid_rst_done", 32'(o_frame_done), 0);
    chk("mid_rst_ready", 32'(o_ready), 0);
    m_state = 0;
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 3; c++) cyc(1, 'h66, 1, 0);
    chk("post_rst_done_count", n_done, 0);

    // Fresh frame restarts at the origin
    cyc(0, 0, 0, 1);
    chk("restart_x", 32'(o_x), 0);
    chk("restart_y", 32'(o_y), 0);
    cyc(1, 'h37, 1, 0);
    chk("restart_addr", 32'(o_addr_wr), 0);
    chk("restart_band", 32'(o_band), 0);
    chk("restart_we", 32'(o_we), 1);
    cyc(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
